// File: rtl/timer_pkg.sv
// Shared constants and state encodings for the programmable timer family.
package timer_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // 499,999 terminal count gives 500,000 ticks per rollover (10 ms at 50 MHz).
  localparam logic [19:0] TEN_MS_PERIOD = 20'h7A11F;
  localparam logic [19:0] RESET_PERIOD  = TEN_MS_PERIOD;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: asserts tick once every prescale+1 enabled clocks.
module timer_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] cnt;

  // >= so that lowering prescale below the current count wraps at once.
  assign tick = en && (cnt >= prescale);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_prog.sv
// Programmable periodic / one-shot timer with prescaler, start/stop control
// and sticky expiry flag. All outputs are registered.
module timer_prog
  import timer_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] period,
  input  logic [PRE_W-1:0] prescale,
  input  logic             clear_expired,
  output logic [WIDTH-1:0] count,
  output logic             rollover,
  output logic             running,
  output logic             expired
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             roll_q, roll_d;
  logic             exp_q, exp_d;
  logic             tick;

  // Any start or stop request realigns the prescaler phase.
  timer_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clr      (start | stop),
    .en       ((state_q == ST_RUN) && enable),
    .prescale (prescale),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      roll_q  <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      roll_q  <= roll_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    roll_d  = 1'b0;
    exp_d   = exp_q & ~clear_expired;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_RUN;
          count_d = '0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          count_d = '0;
        end else if (tick) begin
          // >= so a period lowered mid-run wraps on the next tick.
          if (count_q >= period) begin
            count_d = '0;
            roll_d  = 1'b1;
            if (mode == MODE_ONESHOT) begin
              state_d = ST_IDLE;
              exp_d   = 1'b1;
            end
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign count    = count_q;
  assign rollover = roll_q;
  assign running  = (state_q == ST_RUN);
  assign expired  = exp_q;

endmodule
